regfile_sb: RTL and testbench

- Parametrised successor to the 16x16 two-read/one-write register file used by the ALU datapath.
- Adds registered (1-cycle) reads with write-first bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard for pipelined issue.
- Sits between decode (read addresses, destination claim) and writeback (write port).
- Drives ALU operand latches and the decode stall logic.

---
 rtl/regfile_sb_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults, types and address-qualification helper for the
// scoreboarded register file.
package regfile_sb_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_DEPTH_DEF = 16;

  typedef logic [3:0]  rf_addr_t;
  typedef logic [15:0] rf_data_t;

  // An address names a real, writable register: in range and not a hardwired zero.
  function automatic logic rf_addr_ok(input int unsigned addr,
                                      input int unsigned depth,
                                      input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: claims set, writebacks clear, claim wins on collision.
// Lookups are unblocked by a same-cycle writeback to the looked-up register.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int   DEPTH    = RF_DEPTH_DEF,
  parameter logic ZERO_REG = 1'b0,
  parameter int   ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Clear first, then set, so a new producer issuing alongside a writeback keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wr_en && rf_addr_ok(32'(wr_addr), DEPTH, ZERO_REG))
      busy_d[wr_addr] = 1'b0;
    if (claim_en && rf_addr_ok(32'(claim_addr), DEPTH, ZERO_REG))
      busy_d[claim_addr] = 1'b1;
  end

  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    if (rf_addr_ok(32'(rd_addr_a), DEPTH, ZERO_REG))
      busy_a = busy_q[rd_addr_a] & ~(wr_en && (wr_addr == rd_addr_a));
    if (rf_addr_ok(32'(rd_addr_b), DEPTH, ZERO_REG))
      busy_b = busy_q[rd_addr_b] & ~(wr_en && (wr_addr == rd_addr_b));
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with registered, write-first reads,
// optional hardwired-zero r0 and a busy scoreboard for pipelined issue.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int   WIDTH    = RF_WIDTH_DEF,
  parameter int   DEPTH    = RF_DEPTH_DEF,
  parameter int   ADDR_W   = $clog2(DEPTH),
  parameter logic ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic [WIDTH-1:0] val_a, val_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q      <= '{default: '0};
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en && rf_addr_ok(32'(wr_addr), DEPTH, ZERO_REG))
      regs_d[wr_addr] = wr_data;
  end

  // The bypass only reaches the read-data flops, never the outputs directly.
  always_comb begin
    val_a = '0;
    val_b = '0;
    if (rf_addr_ok(32'(rd_addr_a), DEPTH, ZERO_REG))
      val_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
    if (rf_addr_ok(32'(rd_addr_b), DEPTH, ZERO_REG))
      val_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
    rd_data_a_d = rd_en ? val_a : rd_data_a_q;
    rd_data_b_d = rd_en ? val_b : rd_data_b_q;
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: three configurations (default, hardwired r0, DEPTH=12)
// share one stimulus stream and are checked against hand-computed values.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        claim_en;
  logic [3:0]  claim_addr;

  logic [15:0] d0_a, d0_b, dz_a, dz_b, d12_a, d12_b;
  logic        b0_a, b0_b, bz_a, bz_b, b12_a, b12_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb u0 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d0_a), .rd_data_b(d0_b), .busy_a(b0_a), .busy_b(b0_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr)
  );

  regfile_sb #(.ZERO_REG(1'b1)) uz (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(dz_a), .rd_data_b(dz_b), .busy_a(bz_a), .busy_b(bz_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr)
  );

  regfile_sb #(.DEPTH(12)) u12 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d12_a), .rd_data_b(d12_b), .busy_a(b12_a), .busy_b(b12_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; claim_en = 1'b0; claim_addr = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    chk("reset_rd_a", d0_a, 16'h0000);
    chk("reset_rd_b", d0_b, 16'h0000);
    chk("reset_busy_a", {15'b0, b0_a}, 16'h0000);
    chk("reset_busy_b", {15'b0, b0_b}, 16'h0000);

    // Mid-stream activity, then an asynchronous reset between edges
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h5555; claim_en = 1'b1; claim_addr = 4'd4;
    tick;
    wr_en = 1'b0; claim_en = 1'b0; rd_addr_a = 4'd4;
    #1;
    chk("pre_reset_busy_r4", {15'b0, b0_a}, 16'h0001);
    reset = 1'b1;
    #2;
    chk("async_reset_busy_r4", {15'b0, b0_a}, 16'h0000);
    reset = 1'b0;
    tick;
    rd_en = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd4;
    tick;
    rd_en = 1'b0;
    chk("post_reset_r3", d0_a, 16'h0000);
    chk("post_reset_r4", d0_b, 16'h0000);

    // Write r3, read next cycle
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    tick;
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 4'd3;
    tick;
    rd_en = 1'b0;
    chk("write_read_r3", d0_a, 16'h1234);

    // Write-first bypass on both ports, then hold
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_en = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    tick;
    wr_en = 1'b0; rd_en = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd0;
    chk("bypass_a", d0_a, 16'hBEEF);
    chk("bypass_b", d0_b, 16'hBEEF);
    tick;
    chk("hold_a", d0_a, 16'hBEEF);
    chk("hold_b", d0_b, 16'hBEEF);

    // Zero register: write and claim r0 together
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; claim_en = 1'b1; claim_addr = 4'd0;
    tick;
    wr_en = 1'b0; claim_en = 1'b0; rd_en = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    #1;
    chk("zero_busy_a", {15'b0, bz_a}, 16'h0000);
    chk("nozero_busy_a", {15'b0, b0_a}, 16'h0001);
    tick;
    rd_en = 1'b0;
    chk("zero_rd_a", dz_a, 16'h0000);
    chk("nozero_rd_a", d0_a, 16'hFFFF);

    // Scoreboard: claim r7, then write it back
    claim_en = 1'b1; claim_addr = 4'd7;
    tick;
    claim_en = 1'b0; rd_addr_b = 4'd7;
    #1;
    chk("claim_busy_b", {15'b0, b0_b}, 16'h0001);
    tick;
    chk("claim_busy_b_held", {15'b0, b0_b}, 16'h0001);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0777;
    #1;
    chk("wb_busy_b_comb", {15'b0, b0_b}, 16'h0000);
    tick;
    wr_en = 1'b0;
    #1;
    chk("wb_busy_b_cleared", {15'b0, b0_b}, 16'h0000);

    // Claim and writeback collide on r2
    claim_en = 1'b1; claim_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222; rd_addr_a = 4'd2;
    tick;
    claim_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("collide_busy", {15'b0, b0_a}, 16'h0001);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("collide_data", d0_a, 16'h2222);

    // DEPTH=12: out-of-range address 13 stays zero and never busy
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 16'h0B0B;
    tick;
    wr_addr = 4'd13; wr_data = 16'hAAAA; claim_en = 1'b1; claim_addr = 4'd13;
    tick;
    wr_en = 1'b0; claim_en = 1'b0; rd_en = 1'b1; rd_addr_a = 4'd13; rd_addr_b = 4'd11;
    #1;
    chk("d12_busy_oor", {15'b0, b12_a}, 16'h0000);
    chk("d16_busy_r13", {15'b0, b0_a}, 16'h0001);
    tick;
    rd_en = 1'b0;
    chk("d12_rd_oor", d12_a, 16'h0000);
    chk("d12_rd_r11", d12_b, 16'h0B0B);
    chk("d16_rd_r13", d0_a, 16'hAAAA);

    // Out-of-range read with a matching write must not bypass
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'h5A5A; rd_en = 1'b1; rd_addr_a = 4'd13; rd_addr_b = 4'd12;
    tick;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("d12_bypass_oor_a", d12_a, 16'h0000);
    chk("d12_rd_oor_b", d12_b, 16'h0000);
    chk("d16_bypass_r13", d0_a, 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
